// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, control bundle and ID-stage state type.
// Used by id_decode and id_stage.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic [4:0] dest;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       use_rs;
    logic       use_rt;
  } id_ctrl_t;

  typedef enum logic {RUN, LU_STALL} state_t;

endpackage

// File: rtl/id_decode.sv
// Combinational MIPS decoder: instruction -> control bundle and
// sign-extended 16-bit immediate.
module id_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output id_ctrl_t    ctrl,
  output logic [31:0] imm
);

  logic [5:0] op;

  assign op  = instr[31:26];
  assign imm = {{16{instr[15]}}, instr[15:0]};

  always_comb begin
    ctrl = '0;
    unique case (1'b1)
      op == OP_RTYPE: begin
        ctrl.dest      = instr[15:11];
        ctrl.reg_write = 1'b1;
        ctrl.use_rs    = 1'b1;
        ctrl.use_rt    = 1'b1;
      end
      op == OP_LW: begin
        ctrl.dest      = instr[20:16];
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.use_rs    = 1'b1;
      end
      op == OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.use_rs    = 1'b1;
        ctrl.use_rt    = 1'b1;
      end
      (op == OP_BEQ) || (op == OP_BNE): begin
        ctrl.use_rs = 1'b1;
        ctrl.use_rt = 1'b1;
      end
      (op == OP_J) || (op == OP_JAL): begin
        ctrl = '0;
      end
      default: begin
        ctrl.dest      = instr[20:16];
        ctrl.reg_write = 1'b1;
        ctrl.use_rs    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: IF/ID and ID/EX registers, operand capture, hazard stall.
// Define FWD_EN for the EX/MEM/WB bypass network; otherwise RAW hazards stall.
module id_stage
  import mips_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  input  logic            flush,
  output logic [AW-1:0]   rf_addr1,
  output logic [AW-1:0]   rf_addr2,
  input  logic [XLEN-1:0] rf_data1,
  input  logic [XLEN-1:0] rf_data2,
  input  logic            exf_wen,
  input  logic [AW-1:0]   exf_waddr,
  input  logic [XLEN-1:0] exf_wdata,
  input  logic            exf_load,
  input  logic            memf_wen,
  input  logic [AW-1:0]   memf_waddr,
  input  logic [XLEN-1:0] memf_wdata,
  input  logic            wbf_wen,
  input  logic [AW-1:0]   wbf_waddr,
  input  logic [XLEN-1:0] wbf_wdata,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs_val,
  output logic [XLEN-1:0] ex_rt_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [AW-1:0]   ex_dest,
  output logic [5:0]      ex_opcode,
  output logic [5:0]      ex_funct,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write
);

  logic            id_valid;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  state_t          state_q, state_d;

  id_ctrl_t        ctrl;
  logic [31:0]     imm;
  logic [AW-1:0]   rs, rt;
  logic            ex_m, mem_m, wb_m;
  logic            stall, advance, accept;
  logic [XLEN-1:0] rs_val, rt_val;

  id_decode u_dec (
    .instr (id_instr),
    .ctrl  (ctrl),
    .imm   (imm)
  );

  assign rs       = id_instr[25:21];
  assign rt       = id_instr[20:16];
  assign rf_addr1 = rs;
  assign rf_addr2 = rt;

  // Does a downstream write target a source this instruction reads?
  assign ex_m = exf_wen & (exf_waddr != '0) &
    ((ctrl.use_rs & (exf_waddr == rs)) |
     (ctrl.use_rt & (exf_waddr == rt)));
  assign mem_m = memf_wen & (memf_waddr != '0) &
    ((ctrl.use_rs & (memf_waddr == rs)) |
     (ctrl.use_rt & (memf_waddr == rt)));
  assign wb_m = wbf_wen & (wbf_waddr != '0) &
    ((ctrl.use_rs & (wbf_waddr == rs)) |
     (ctrl.use_rt & (wbf_waddr == rt)));

`ifdef FWD_EN
  logic unused;
  assign unused = mem_m ^ wb_m;
  assign stall  = id_valid & ex_m & exf_load;

  // Youngest producer wins; a load still in EX is covered by the stall.
  assign rs_val = (rs == '0) ? '0 :
    (exf_wen & !exf_load & (exf_waddr == rs)) ? exf_wdata :
    (memf_wen & (memf_waddr == rs)) ? memf_wdata :
    (wbf_wen & (wbf_waddr == rs)) ? wbf_wdata : rf_data1;
  assign rt_val = (rt == '0) ? '0 :
    (exf_wen & !exf_load & (exf_waddr == rt)) ? exf_wdata :
    (memf_wen & (memf_waddr == rt)) ? memf_wdata :
    (wbf_wen & (wbf_waddr == rt)) ? wbf_wdata : rf_data2;
`else
  logic unused;
  assign unused = ^{exf_wdata, memf_wdata, wbf_wdata, exf_load};
  // WB hit stalls too: the regfile write only lands at the edge.
  assign stall  = id_valid & (ex_m | mem_m | wb_m);
  assign rs_val = (rs == '0) ? '0 : rf_data1;
  assign rt_val = (rt == '0) ? '0 : rf_data2;
`endif

  assign advance  = id_valid & !stall & (!ex_valid | ex_ready);
  assign id_ready = !flush & (!id_valid | advance);
  assign accept   = if_valid & id_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:      if (stall) state_d = LU_STALL;
      LU_STALL: state_d = stall ? LU_STALL : RUN;
      default:  state_d = RUN;
    endcase
    if (flush) state_d = RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc    <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        id_valid <= 1'b0;
      end else if (accept) begin
        id_valid <= 1'b1;
        id_instr <= if_instr;
        id_pc    <= if_pc;
      end else if (advance) begin
        id_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs_val    <= '0;
      ex_rt_val    <= '0;
      ex_imm       <= '0;
      ex_dest      <= '0;
      ex_opcode    <= '0;
      ex_funct     <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (!ex_valid | ex_ready) begin
      ex_valid <= advance;
      if (advance) begin
        ex_pc        <= id_pc;
        ex_rs_val    <= rs_val;
        ex_rt_val    <= rt_val;
        ex_imm       <= imm;
        ex_dest      <= ctrl.dest;
        ex_opcode    <= id_instr[31:26];
        ex_funct     <= id_instr[5:0];
        ex_reg_write <= ctrl.reg_write;
        ex_mem_read  <= ctrl.mem_read;
        ex_mem_write <= ctrl.mem_write;
      end
    end
  end

endmodule
